// File: rtl/stark_decode_cjb_grp.sv
// rtl/stark_decode_cjb_grp.sv - multi-lane conditional-branch classifier with 2-entry skid output
// Optional STARK_CJB_STATS_EN adds a saturating stat_cjb_total counter of transferred branches.
package Stark_pkg;
  typedef logic [6:0] opcode_t;

  localparam opcode_t OP_ADD = 7'h33;
  localparam opcode_t OP_B0  = 7'h63;
  localparam opcode_t OP_B1  = 7'h67;

  typedef struct packed {
    logic [24:0] operands;
    opcode_t     opcode;
  } any_fmt_t;

  typedef union packed {
    any_fmt_t    any;
    logic [31:0] raw;
  } instruction_t;
endpackage

module stark_decode_cjb_grp
  import Stark_pkg::*;
#(
  parameter int NLANES = 4,
  parameter int LW     = (NLANES > 1) ? $clog2(NLANES) : 1,
  parameter int CW     = $clog2(NLANES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NLANES-1:0]          lane_en,
  input  instruction_t [NLANES-1:0]  instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NLANES-1:0]          cjb,
  output logic                       any_cjb,
  output logic [LW-1:0]              first_idx,
  output logic [CW-1:0]              cjb_cnt
`ifdef STARK_CJB_STATS_EN
  ,
  output logic [31:0]                stat_cjb_total
`endif
);

  typedef struct packed {
    logic [NLANES-1:0] cjb;
    logic              any;
    logic [LW-1:0]     first;
    logic [CW-1:0]     cnt;
  } res_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state, state_d;
  res_t   res_c, main_q, skid_q;
  logic   in_ready_q;
  logic   accept, transfer;
  logic   load_main, load_skid, move_skid;
  logic   unused_operands;

  // Walk from the top lane down so the last hit is the lowest index.
  always_comb begin
    res_c           = '0;
    unused_operands = 1'b0;
    for (int i = NLANES - 1; i >= 0; i--) begin
      unused_operands = unused_operands ^ (^instr[i].any.operands);
      if (lane_en[i] && (instr[i].any.opcode == OP_B0 || instr[i].any.opcode == OP_B1)) begin
        res_c.cjb[i] = 1'b1;
        res_c.first  = LW'(i);
        res_c.cnt    = res_c.cnt + CW'(1);
      end
    end
    res_c.any = |res_c.cjb;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign transfer  = out_valid && out_ready;

  always_comb begin
    state_d   = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && !transfer) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (accept && transfer) begin
            load_main = 1'b1;
          end else if (transfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (transfer) begin
            state_d   = ONE;
            move_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_d;
      in_ready_q <= (state_d != TWO);
      if (load_main) begin
        main_q <= res_c;
      end else if (move_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= res_c;
      end
    end
  end

  // Main holds stale data after draining, so gate it off when idle.
  always_comb begin
    cjb       = '0;
    any_cjb   = 1'b0;
    first_idx = '0;
    cjb_cnt   = '0;
    if (out_valid) begin
      cjb       = main_q.cjb;
      any_cjb   = main_q.any;
      first_idx = main_q.first;
      cjb_cnt   = main_q.cnt;
    end
  end

`ifdef STARK_CJB_STATS_EN
  logic [32:0] stat_sum;

  assign stat_sum = {1'b0, stat_cjb_total} + 33'(main_q.cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cjb_total <= '0;
    end else if (transfer) begin
      stat_cjb_total <= stat_sum[32] ? 32'hFFFF_FFFF : stat_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_stark_decode_cjb_grp.sv
// tb/tb_stark_decode_cjb_grp.sv - scoreboard bench for stark_decode_cjb_grp (NLANES=4)
module tb_stark_decode_cjb_grp;
  import Stark_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] lane_en, cjb;
  instruction_t [3:0] instr;
  logic any_cjb;
  logic [1:0] first_idx;
  logic [2:0] cjb_cnt;
`ifdef STARK_CJB_STATS_EN
  logic [31:0] stat_cjb_total;
`endif

  typedef struct packed {
    logic [3:0] cjb;
    logic       any;
    logic [1:0] first;
    logic [2:0] cnt;
  } exp_t;

  exp_t    sbq[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  int      n_pop    = 0;
  longint  exp_total = 0;

  stark_decode_cjb_grp #(.NLANES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .lane_en(lane_en), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .cjb(cjb), .any_cjb(any_cjb), .first_idx(first_idx), .cjb_cnt(cjb_cnt)
`ifdef STARK_CJB_STATS_EN
    , .stat_cjb_total(stat_cjb_total)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          e = sbq.pop_front();
          check("group", 64'({cjb, any_cjb, first_idx, cjb_cnt}), 64'(e));
          exp_total += e.cnt;
          n_pop++;
        end
      end else if (!out_valid) begin
        check("idle_zero", 64'({cjb, any_cjb, first_idx, cjb_cnt}), 64'd0);
      end
    end
  end

  function automatic instruction_t mk(input opcode_t op);
    instruction_t r;
    r.raw            = 32'h0;
    r.any.operands   = 25'h1_5a3c;
    r.any.opcode     = op;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Opcodes listed lane 3 down to lane 0.
  task automatic set_grp(input logic [3:0] en, input opcode_t o3, o2, o1, o0);
    lane_en = en;
    instr   = {mk(o3), mk(o2), mk(o1), mk(o0)};
  endtask

  task automatic send(input logic [3:0] en, input opcode_t o3, o2, o1, o0, input exp_t e);
    int waitc = 0;
    set_grp(en, o3, o2, o1, o0);
    in_valid = 1'b1;
    while (!in_ready && waitc < 20) begin
      tick(1);
      waitc++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    else sbq.push_back(e);
    tick(1);
    in_valid = 1'b0;
    lane_en  = 4'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pops0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    lane_en = 4'b0; instr = '0;
    tick(2);
    check("reset_outputs", 64'({out_valid, in_ready, cjb, any_cjb, first_idx, cjb_cnt}), 64'd0);
    rst = 1'b0;
    tick(1);
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    out_ready = 1'b1;
    send(4'b1111, OP_ADD, OP_B1, OP_B0, OP_ADD, {4'b0110, 1'b1, 2'd1, 3'd2});
    send(4'b1101, OP_B0,  OP_B0, OP_B0, OP_B0,  {4'b1101, 1'b1, 2'd0, 3'd3});
    send(4'b1111, OP_ADD, OP_ADD, OP_ADD, OP_ADD, {4'b0000, 1'b0, 2'd0, 3'd0});
    send(4'b1111, OP_B1,  OP_B1, OP_B1, OP_B1,  {4'b1111, 1'b1, 2'd0, 3'd4});
    send(4'b1000, OP_B0,  OP_B0, OP_B0, OP_B0,  {4'b1000, 1'b1, 2'd3, 3'd1});
    send(4'b1111, OP_ADD, OP_B1, OP_ADD, OP_ADD, {4'b0100, 1'b1, 2'd2, 3'd1});
    send(4'b0000, OP_B0,  OP_B0, OP_B0, OP_B0,  {4'b0000, 1'b0, 2'd0, 3'd0});
    tick(3);

    out_ready = 1'b0;
    send(4'b0011, OP_B0, OP_B0, OP_B1, OP_ADD, {4'b0010, 1'b1, 2'd1, 3'd1});
    send(4'b1111, OP_ADD, OP_ADD, OP_ADD, OP_B1, {4'b0001, 1'b1, 2'd0, 3'd1});
    check("in_ready_two", 64'(in_ready), 64'd0);
    check("out_valid_two", 64'(out_valid), 64'd1);
    pops0 = n_pop;
    out_ready = 1'b1;
    tick(1);
    check("drain_first", 64'(n_pop), 64'(pops0 + 1));
    check("in_ready_back", 64'(in_ready), 64'd1);
    tick(1);
    check("drain_second", 64'(n_pop), 64'(pops0 + 2));
    check("empty_after_drain", 64'(out_valid), 64'd0);

    out_ready = 1'b0;
    send(4'b1111, OP_ADD, OP_ADD, OP_ADD, OP_ADD, {4'b0000, 1'b0, 2'd0, 3'd0});
    send(4'b0110, OP_B0,  OP_B0, OP_B0, OP_B0,   {4'b0110, 1'b1, 2'd1, 3'd2});
    check("in_ready_two_b", 64'(in_ready), 64'd0);
    set_grp(4'b1111, OP_B0, OP_B0, OP_B0, OP_B0);
    in_valid = 1'b1;
    flush = 1'b1;
    sbq.delete();
    tick(1);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick(3);

    set_grp(4'b1111, OP_B1, OP_B0, OP_B1, OP_B0);
    in_valid = 1'b1;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_accept_dropped", 64'(out_valid), 64'd0);
    tick(2);

`ifdef STARK_CJB_STATS_EN
    check("stat_total", 64'(stat_cjb_total), 64'(exp_total));
`endif

    out_ready = 1'b0;
    send(4'b1111, OP_B1, OP_ADD, OP_ADD, OP_ADD, {4'b1000, 1'b1, 2'd3, 3'd1});
    check("one_before_rst", 64'(out_valid), 64'd1);
    rst = 1'b1;
    sbq.delete();
    exp_total = 0;
    tick(1);
    check("rst_outputs", 64'({out_valid, in_ready, cjb, any_cjb, first_idx, cjb_cnt}), 64'd0);
    rst = 1'b0;
    tick(1);
    check("in_ready_after_rst2", 64'(in_ready), 64'd1);

`ifdef STARK_CJB_STATS_EN
    check("stat_rst", 64'(stat_cjb_total), 64'd0);
    out_ready = 1'b1;
    send(4'b1101, OP_B0, OP_B0, OP_B0, OP_B0, {4'b1101, 1'b1, 2'd0, 3'd3});
    tick(2);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("stat_after_flush", 64'(stat_cjb_total), 64'd3);
`endif

    tick(2);
    check("sb_drained", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
